appx_mac_acc: RTL and testbench
===============================

APPX_MAC_ACC -- requirements
Module: appx_mac_acc

Interface
- REQ-001 Parameter ACC_W, default 40: accumulator and result width in bits, minimum 32.
- REQ-002 Parameter CNT_W, default 8: width of the product counter in bits.
- REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
- REQ-004 clk  input  1: the single clock; all state updates on its rising edge.
- REQ-005 rst  input  1: synchronous active-high reset.
- REQ-006 in_valid  input  1: in_prod and in_last are valid this cycle.
- REQ-007 in_ready  output  1: block can accept a product this cycle.
- REQ-008 in_prod  input  32: unsigned product from the approximate 16x16 multiplier stage.
- REQ-009 in_last  input  1: this product is the final term of the current dot product.
- REQ-010 out_valid  output  1: a result is presented.
- REQ-011 out_ready  input  1: the consumer accepts the result.
- REQ-012 out_sum  output  ACC_W: accumulated sum.
- REQ-013 out_count  output  CNT_W: number of products in the sum.
- REQ-014 out_ovf  output  1: the accumulator overflowed during this vector.

Function
- REQ-015 The FSM has two states: ACCUM and HOLD. Reset enters ACCUM.
- REQ-016 In ACCUM, in_ready=1 and out_valid=0. In HOLD, in_ready=0 and out_valid=1.
- REQ-017 A product is accepted when in_valid and in_ready are both 1. On acceptance: acc <= acc + zero-extended in_prod, and cnt <= cnt+1.
- REQ-018 cnt saturates at 2^CNT_W-1. It never wraps.
- REQ-019 Accepting a product with in_last=1 moves ACCUM to HOLD. out_valid rises the next cycle, and out_sum includes that product (latency 1 cycle).
- REQ-020 In HOLD, out_sum, out_count and out_ovf are stable until out_valid and out_ready are both 1.
- REQ-021 On that handshake: go to ACCUM, and clear acc, cnt and ovf to 0 in the same edge. The next product can be accepted the following cycle.
- REQ-022 out_ready has no effect in ACCUM. in_valid has no effect in HOLD.
- REQ-023 ovf is sticky per vector. It is set when an addition carries out of ACC_W bits.
- REQ-024 out_sum and out_count are driven directly from registers, with no combinational path from the inputs.

Reset
- REQ-025 When rst=1 at a clock edge: state=ACCUM, acc=0, cnt=0, ovf=0. As a result in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- REQ-026 Reset takes priority over any simultaneous handshake. A partial vector or a held result is discarded.

Configuration
- REQ-027 With macro APPX_MAC_SAT_EN defined, an overflowing addition clamps acc to 2^ACC_W-1 and sets ovf. Further additions keep acc at that value.
- REQ-028 Without APPX_MAC_SAT_EN, acc wraps modulo 2^ACC_W and sets ovf.

Structure
- REQ-029 Shared package appx_pkg contains the state enum type and the PROD_W=32 constant.
- REQ-030 The add/overflow/saturate logic is a sub-module named appx_sat_add (ports a, b, sum, carry). appx_mac_acc instantiates it once.

Verification
- REQ-031 Vector test: products 0x100, 0x200, 0x400 (last) with out_ready=1 -> out_sum=0x700, out_count=3, out_ovf=0, out_valid high for exactly 1 cycle.
- REQ-032 Back-pressure test: single product 0x8000 (last), out_ready=0 for 5 cycles -> out_valid=1 and in_ready=0 held for 5 cycles with out_sum=0x8000, then the handshake occurs and in_ready=1 on the next cycle.
- REQ-033 Overflow test: ACC_W=32, products 0xFFFF0000 then 0x00020000 (last) -> out_ovf=1. out_sum=0xFFFFFFFF with APPX_MAC_SAT_EN, and out_sum=0x00010000 without it.
- REQ-034 Reset test: rst=1 after 2 accepted products of a vector -> next cycle out_sum=0, out_count=0, in_ready=1. A following product 0x10 (last) yields out_sum=0x10, out_count=1.
- REQ-035 Back-to-back test: two vectors {0x1, 0x2 last} and {0x4 last} with out_ready=1 and in_valid continuously high -> results 0x3 then 0x4, and no product is lost while in HOLD.
- REQ-036 Counter saturation test: CNT_W=2, five products of 0x1 (fifth last) -> out_count=3, out_sum=0x5.

Source files
------------

// File: rtl/appx_pkg.sv
// Shared types and constants for the approximate MAC accumulator.
package appx_pkg;

   localparam int unsigned PROD_W = 32;

   typedef enum logic {
      StAccum = 1'b0,
      StHold  = 1'b1
   } state_e;

endpackage

// File: rtl/appx_sat_add.sv
// Unsigned adder reporting carry-out; clamps to all-ones when APPX_MAC_SAT_EN is defined,
// otherwise wraps modulo 2^W.
module appx_sat_add
   import appx_pkg::*;
#(
   parameter int unsigned W = 40
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         carry
);

   logic [W:0] full;

   always_comb begin
      full  = {1'b0, a} + {1'b0, b};
      carry = full[W];
`ifdef APPX_MAC_SAT_EN
      sum   = carry ? {W{1'b1}} : full[W-1:0];
`else
      sum   = full[W-1:0];
`endif
   end

endmodule

// File: rtl/appx_mac_acc.sv
// Dot-product accumulator: sums a vector of products, then holds the result until consumed.
// Optional saturation instead of wrap-around is enabled by defining APPX_MAC_SAT_EN.
module appx_mac_acc
   import appx_pkg::*;
#(
   parameter int unsigned ACC_W = 40,
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   state_e             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;
   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W-1:0]   add_sum;
   logic               add_carry;

   assign prod_ext = ACC_W'(in_prod);

   appx_sat_add #(
      .W(ACC_W)
   ) u_add (
      .a    (acc_q),
      .b    (prod_ext),
      .sum  (add_sum),
      .carry(add_carry)
   );

   // Handshake flags decode the state register only, so no input reaches an output.
   assign in_ready  = (state_q == StAccum);
   assign out_valid = (state_q == StHold);
   assign out_sum   = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StAccum;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StAccum: begin
               if (in_valid) begin
                  acc_q <= add_sum;
                  ovf_q <= ovf_q | add_carry;
                  if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
                  if (in_last) state_q <= StHold;
               end
            end
            StHold: begin
               if (out_ready) begin
                  state_q <= StAccum;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  ovf_q   <= 1'b0;
               end
            end
            default: state_q <= StAccum;
         endcase
      end
   end

endmodule

// File: tb/tb_appx_mac_acc.sv
// Self-checking bench for appx_mac_acc: transaction-level model compared every cycle,
// plus directed vectors with literal expectations. Honours APPX_MAC_SAT_EN.
module tb_appx_mac_acc;

   localparam int unsigned AW = 32;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_prod;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_sum;
   logic [CW-1:0] out_count;
   logic          out_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: exact (unbounded) running sum and product count of the current vector.
   bit              m_hold = 1'b0;
   longint unsigned m_sum  = 0;
   int              m_n    = 0;
   bit              chk_en = 1'b0;

   appx_mac_acc #(
      .ACC_W(AW),
      .CNT_W(CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_prod  (in_prod),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_count(out_count),
      .out_ovf  (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] exp_sum();
`ifdef APPX_MAC_SAT_EN
      return (m_sum > 64'hFFFF_FFFF) ? {AW{1'b1}} : m_sum[AW-1:0];
`else
      return m_sum[AW-1:0];
`endif
   endfunction

   function automatic logic [CW-1:0] exp_count();
      return (m_n > 3) ? 2'd3 : m_n[CW-1:0];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_hold = 1'b0;
         m_sum  = 0;
         m_n    = 0;
      end else if (!m_hold && in_valid) begin
         m_sum = m_sum + longint'(in_prod);
         m_n++;
         if (in_last) m_hold = 1'b1;
      end else if (m_hold && out_ready) begin
         m_hold = 1'b0;
         m_sum  = 0;
         m_n    = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model in_ready", 64'(in_ready), 64'(!m_hold));
         check("model out_valid", 64'(out_valid), 64'(m_hold));
         check("model out_sum", 64'(out_sum), 64'(exp_sum()));
         check("model out_count", 64'(out_count), 64'(exp_count()));
         check("model out_ovf", 64'(out_ovf), 64'(m_sum > 64'hFFFF_FFFF));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a product and keep in_valid high; returns once it has been accepted.
   task automatic send(input logic [31:0] prod, input logic last);
      bit was_ready;
      bit done = 1'b0;
      in_valid = 1'b1;
      in_prod  = prod;
      in_last  = last;
      for (int i = 0; i < 50; i++) begin
         was_ready = in_ready;
         tick();
         if (was_ready) begin
            done = 1'b1;
            break;
         end
      end
      check("send accepted", 64'(done), 64'd1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_sum", 64'(out_sum), 64'd0);
      check("reset out_count", 64'(out_count), 64'd0);
      check("reset out_ovf", 64'(out_ovf), 64'd0);

      // Three-term vector, consumer always ready.
      out_ready = 1'b1;
      send(32'h100, 1'b0);
      send(32'h200, 1'b0);
      send(32'h400, 1'b1);
      idle();
      check("vec out_valid", 64'(out_valid), 64'd1);
      check("vec out_sum", 64'(out_sum), 64'h700);
      check("vec out_count", 64'(out_count), 64'd3);
      check("vec out_ovf", 64'(out_ovf), 64'd0);
      tick();
      check("vec out_valid one cycle", 64'(out_valid), 64'd0);
      check("vec in_ready back", 64'(in_ready), 64'd1);

      // Back-pressure: result held for five cycles.
      out_ready = 1'b0;
      send(32'h8000, 1'b1);
      idle();
      for (int i = 0; i < 5; i++) begin
         check("bp out_valid", 64'(out_valid), 64'd1);
         check("bp in_ready", 64'(in_ready), 64'd0);
         check("bp out_sum", 64'(out_sum), 64'h8000);
         tick();
      end
      out_ready = 1'b1;
      check("bp still held", 64'(out_valid), 64'd1);
      tick();
      check("bp in_ready after", 64'(in_ready), 64'd1);
      check("bp out_valid after", 64'(out_valid), 64'd0);

      // Overflow of a 32-bit accumulator.
      send(32'hFFFF_0000, 1'b0);
      send(32'h0002_0000, 1'b1);
      idle();
      check("ovf out_ovf", 64'(out_ovf), 64'd1);
`ifdef APPX_MAC_SAT_EN
      check("ovf out_sum", 64'(out_sum), 64'hFFFF_FFFF);
`else
      check("ovf out_sum", 64'(out_sum), 64'h0001_0000);
`endif
      check("ovf out_count", 64'(out_count), 64'd2);
      tick();
      check("ovf cleared", 64'(out_ovf), 64'd0);

      // Reset in the middle of a vector.
      send(32'h5, 1'b0);
      send(32'h6, 1'b0);
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst out_sum", 64'(out_sum), 64'd0);
      check("rst out_count", 64'(out_count), 64'd0);
      check("rst in_ready", 64'(in_ready), 64'd1);
      send(32'h10, 1'b1);
      idle();
      check("rst next out_sum", 64'(out_sum), 64'h10);
      check("rst next out_count", 64'(out_count), 64'd1);
      tick();

      // Reset wins over a simultaneous output handshake.
      out_ready = 1'b0;
      send(32'h7, 1'b1);
      idle();
      rst       = 1'b1;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      check("rst hold out_valid", 64'(out_valid), 64'd0);
      check("rst hold out_sum", 64'(out_sum), 64'd0);

      // Back-to-back vectors with in_valid held high throughout.
      send(32'h1, 1'b0);
      send(32'h2, 1'b1);
      check("b2b first sum", 64'(out_sum), 64'h3);
      check("b2b first valid", 64'(out_valid), 64'd1);
      send(32'h4, 1'b1);
      check("b2b second sum", 64'(out_sum), 64'h4);
      check("b2b second count", 64'(out_count), 64'd1);
      idle();
      tick();

      // Counter saturation at 2^CW-1.
      for (int i = 0; i < 4; i++) send(32'h1, 1'b0);
      send(32'h1, 1'b1);
      idle();
      check("sat out_count", 64'(out_count), 64'd3);
      check("sat out_sum", 64'(out_sum), 64'h5);
      tick();
      tick();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
